// File: rtl/exec_ctrl_if.sv
// Fetch handshake plus execute-stage control bus of exec_ctrl.
// master = controller side, slave = fetch/execute side.
interface exec_ctrl_if #(
    parameter int RW         = 16,
    parameter int REGNO_LOG  = 3,
    parameter int REGNO      = 8,
    parameter int ALU_MODE_W = 4
);
    logic [RW-1:0]         i_instr;
    logic                  i_instr_valid;
    logic                  o_instr_ready;
    logic                  o_flush;
    logic                  i_ex_ready;
    logic                  i_resume;
    logic                  o_halted;
    logic                  o_illegal;
    logic [RW-1:0]         o_imm;
    logic                  c_pc_inc;
    logic                  c_pc_ie;
    logic                  c_r_bus_imm;
    logic                  c_alu_carry_en;
    logic                  c_alu_flags_ie;
    logic [ALU_MODE_W-1:0] c_alu_mode;
    logic [REGNO_LOG-1:0]  c_l_reg_sel;
    logic [REGNO_LOG-1:0]  c_r_reg_sel;
    logic [REGNO-1:0]      c_rf_ie;

    modport master (
        input  i_instr, i_instr_valid, i_ex_ready, i_resume,
        output o_instr_ready, o_flush, o_halted, o_illegal, o_imm,
               c_pc_inc, c_pc_ie, c_r_bus_imm, c_alu_carry_en, c_alu_flags_ie,
               c_alu_mode, c_l_reg_sel, c_r_reg_sel, c_rf_ie
    );

    modport slave (
        output i_instr, i_instr_valid, i_ex_ready, i_resume,
        input  o_instr_ready, o_flush, o_halted, o_illegal, o_imm,
               c_pc_inc, c_pc_ie, c_r_bus_imm, c_alu_carry_en, c_alu_flags_ie,
               c_alu_mode, c_l_reg_sel, c_r_reg_sel, c_rf_ie
    );
endinterface

// File: rtl/exec_ctrl.sv
// Decode/sequencing controller: 2 cycles per one-word op, 3 per two-word op; holds in EXEC while i_ex_ready=0.
// Optional EXEC_CTRL_RETIRE_CNT_EN adds the o_retired counter of executed instructions.
module exec_ctrl #(
    parameter int              RW         = 16,
    parameter int              REGNO_LOG  = 3,
    parameter int              REGNO      = 8,
    parameter int              ALU_MODE_W = 4,
    parameter logic [ALU_MODE_W-1:0] ALU_PASS_R = 4'hF
) (
    input  logic          i_clk,
    input  logic          i_rst,
    exec_ctrl_if.master   bus
`ifdef EXEC_CTRL_RETIRE_CNT_EN
    ,
    output logic [RW-1:0] o_retired
`endif
);
    typedef enum logic [1:0] {S_FETCH, S_IMM, S_EXEC, S_HALT} state_t;

    localparam logic [2:0] OP_ALU_RR  = 3'd1;
    localparam logic [2:0] OP_ALU_RI  = 3'd2;
    localparam logic [2:0] OP_ALU_RRC = 3'd3;
    localparam logic [2:0] OP_JMP_I   = 3'd4;
    localparam logic [2:0] OP_HALT    = 3'd5;

    state_t        state, state_nxt;
    logic [RW-1:0] ir, imm_q;
    logic          instr_ready;
    logic          accept;
    logic [2:0]    op, fetch_op;

    assign accept   = instr_ready & bus.i_instr_valid;
    assign op       = ir[2:0];
    assign fetch_op = bus.i_instr[2:0];
    assign bus.o_instr_ready = instr_ready;
    assign bus.o_imm         = imm_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= S_FETCH;
            ir    <= '0;
            imm_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_FETCH && accept) ir    <= bus.i_instr;
            if (state == S_IMM && accept)   imm_q <= bus.i_instr;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH: if (accept) begin
                if (fetch_op == OP_ALU_RI || fetch_op == OP_JMP_I) state_nxt = S_IMM;
                else if (fetch_op[2:1] == 2'b11)                   state_nxt = S_FETCH;
                else                                               state_nxt = S_EXEC;
            end
            S_IMM:   if (accept) state_nxt = S_EXEC;
            S_EXEC:  if (bus.i_ex_ready) state_nxt = (op == OP_HALT) ? S_HALT : S_FETCH;
            S_HALT:  if (bus.i_resume) state_nxt = S_FETCH;
            default: state_nxt = S_FETCH;
        endcase
    end

    // Everything is forced low while reset is held, including the FETCH-state ready.
    always_comb begin
        instr_ready        = 1'b0;
        bus.o_flush        = 1'b0;
        bus.o_halted       = 1'b0;
        bus.o_illegal      = 1'b0;
        bus.c_pc_inc       = 1'b0;
        bus.c_pc_ie        = 1'b0;
        bus.c_r_bus_imm    = 1'b0;
        bus.c_alu_carry_en = 1'b0;
        bus.c_alu_flags_ie = 1'b0;
        bus.c_alu_mode     = '0;
        bus.c_l_reg_sel    = '0;
        bus.c_r_reg_sel    = '0;
        bus.c_rf_ie        = '0;
        if (!i_rst) begin
            case (state)
                S_FETCH: begin
                    instr_ready   = 1'b1;
                    bus.c_pc_inc  = bus.i_instr_valid;
                    bus.o_illegal = bus.i_instr_valid && (fetch_op[2:1] == 2'b11);
                end
                S_IMM: begin
                    instr_ready  = 1'b1;
                    bus.c_pc_inc = bus.i_instr_valid;
                end
                S_EXEC: begin
                    bus.c_l_reg_sel = ir[12:10];
                    bus.c_r_reg_sel = ir[15:13];
                    bus.c_alu_mode  = (op == OP_JMP_I) ? ALU_PASS_R : ir[6:3];
                    bus.c_r_bus_imm = (op == OP_ALU_RI) || (op == OP_JMP_I);
                    if (bus.i_ex_ready) begin
                        if (op == OP_ALU_RR || op == OP_ALU_RI || op == OP_ALU_RRC) begin
                            bus.c_rf_ie        = {{(REGNO-1){1'b0}}, 1'b1} << ir[9:7];
                            bus.c_alu_flags_ie = 1'b1;
                            bus.c_alu_carry_en = (op == OP_ALU_RRC);
                        end else if (op == OP_JMP_I) begin
                            bus.c_pc_ie = 1'b1;
                            bus.o_flush = 1'b1;
                        end
                    end
                end
                S_HALT:  bus.o_halted = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef EXEC_CTRL_RETIRE_CNT_EN
    logic [RW-1:0] retire_cnt;
    logic          retire_inc;

    assign retire_inc = (state == S_EXEC) && bus.i_ex_ready;
    assign o_retired  = retire_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) retire_cnt <= '0;
        else       retire_cnt <= retire_cnt + RW'(retire_inc);
    end
`endif
endmodule
